// File: rtl/p4_router_queue_pkg.sv
// Shared types and constants for the router page allocator.
package p4_router_queue_pkg;

  localparam int DOUBLE_FREE_COUNT_WIDTH = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/p4_router_page_allocator_if.sv
// Valid/ready stream interface carrying page indices to and from the allocator.
interface AXIS_int #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport Master (output tvalid, output tdata, input tready);
  modport Slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/p4_router_page_allocator_rr_arbiter.sv
// Round-robin grant of one requester per cycle; priority moves past the last winner.
module p4_router_rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 sresetn,
  input  logic                 enable,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_any
);

  logic [IDX_W-1:0] prio;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (enable && !grant_any && req[wrap_add(prio, i)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(prio, i);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      prio <= '0;
    end else if (grant_any) begin
      prio <= wrap_add(grant_idx, 1);
    end
  end

endmodule

// File: rtl/p4_router_page_allocator.sv
// Page allocator: circular free list in RAM feeding an output register, with round-robin free return.
// Optional allocated-page bitmap for double-free detection: P4_ROUTER_PAGE_ALLOC_DOUBLE_FREE_CHECK_EN.
//
// state   | meaning
// ST_INIT | writing page indices 0..N-1 into the free list, streams stalled
// ST_RUN  | allocating and accepting returned pages
module p4_router_page_allocator
  import p4_router_queue_pkg::*;
#(
  parameter int NUM_PAGES_LOG  = 10,
  parameter int NUM_FREE_PORTS = 2,
  parameter int DATA_W         = 16
) (
  input  logic                               clk,
  input  logic                               sresetn,
  AXIS_int.Master                            alloc_out,
  AXIS_int.Slave                             free_in [NUM_FREE_PORTS],
  output logic                               init_done,
  output logic [NUM_PAGES_LOG:0]             num_free_pages,
  output logic                               overflow_err,
  output logic                               double_free_err,
  output logic [DOUBLE_FREE_COUNT_WIDTH-1:0] double_free_count
);

  localparam int N      = 2 ** NUM_PAGES_LOG;
  localparam int CW     = NUM_PAGES_LOG + 1;
  localparam int PIDX_W = (NUM_FREE_PORTS > 1) ? $clog2(NUM_FREE_PORTS) : 1;
  localparam logic [CW-1:0]            FULL_CNT = CW'(N);
  localparam logic [CW-1:0]            ONE_C    = CW'(1);
  localparam logic [NUM_PAGES_LOG-1:0] ONE_P    = NUM_PAGES_LOG'(1);

  alloc_state_t state, state_next;
  logic init_wr, run_en;

  logic [NUM_PAGES_LOG-1:0] mem [N];
  logic [NUM_PAGES_LOG-1:0] wr_ptr, rd_ptr, rd_data, out_data;
  logic [CW-1:0]            fifo_cnt;
  logic                     rd_valid, out_valid;

  logic [NUM_FREE_PORTS-1:0] free_valid, free_grant;
  logic [NUM_PAGES_LOG-1:0]  free_page [NUM_FREE_PORTS];
  logic [PIDX_W-1:0]         grant_idx;
  logic                      free_acc;
  logic [NUM_PAGES_LOG-1:0]  acc_page;

  logic pop, list_full, dbl_hit, ovf_hit, wr_en, fifo_empty, load_out, issue, init_last;

  always_ff @(posedge clk) begin
    if (!sresetn) state <= ST_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (wr_ptr == '1) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    init_wr = 1'b0;
    run_en  = 1'b0;
    case (state)
      ST_INIT: init_wr = 1'b1;
      ST_RUN:  run_en  = 1'b1;
      default: ;
    endcase
  end

  assign init_done = run_en;

  for (genvar g = 0; g < NUM_FREE_PORTS; g++) begin : g_free
    assign free_valid[g]     = free_in[g].tvalid;
    assign free_page[g]      = NUM_PAGES_LOG'(free_in[g].tdata);
    assign free_in[g].tready = free_grant[g];
  end

  p4_router_rr_arbiter #(.NUM_PORTS(NUM_FREE_PORTS)) u_arb (
    .clk       (clk),
    .sresetn   (sresetn),
    .enable    (run_en),
    .req       (free_valid),
    .grant     (free_grant),
    .grant_idx (grant_idx),
    .grant_any (free_acc)
  );

  assign acc_page   = free_page[grant_idx];
  assign pop        = out_valid && alloc_out.tready;
  assign list_full  = (num_free_pages == FULL_CNT);
  assign ovf_hit    = free_acc && list_full;
  assign wr_en      = free_acc && !list_full && !dbl_hit;
  assign fifo_empty = (fifo_cnt == '0);
  assign load_out   = rd_valid && (!out_valid || pop);
  assign init_last  = init_wr && (wr_ptr == '1);
  // A page written into an empty list is forwarded straight into the read stage.
  assign issue      = run_en && (!fifo_empty || wr_en) && (!rd_valid || load_out);

  assign alloc_out.tvalid = out_valid;
  assign alloc_out.tdata  = DATA_W'(out_data);

  always_ff @(posedge clk) begin
    if (init_wr)    mem[wr_ptr] <= wr_ptr;
    else if (wr_en) mem[wr_ptr] <= acc_page;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      num_free_pages <= '0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      overflow_err   <= 1'b0;
    end else begin
      overflow_err <= ovf_hit;
      if (init_wr || wr_en) wr_ptr <= wr_ptr + ONE_P;
      if (issue) begin
        rd_ptr   <= rd_ptr + ONE_P;
        rd_data  <= fifo_empty ? acc_page : mem[rd_ptr];
        rd_valid <= 1'b1;
      end else if (load_out) begin
        rd_valid <= 1'b0;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (init_last)             fifo_cnt <= FULL_CNT;
      else if (wr_en && !issue)  fifo_cnt <= fifo_cnt + ONE_C;
      else if (!wr_en && issue)  fifo_cnt <= fifo_cnt - ONE_C;
      if (init_last)             num_free_pages <= FULL_CNT;
      else if (wr_en && !pop)    num_free_pages <= num_free_pages + ONE_C;
      else if (!wr_en && pop)    num_free_pages <= num_free_pages - ONE_C;
    end
  end

`ifdef P4_ROUTER_PAGE_ALLOC_DOUBLE_FREE_CHECK_EN
  logic [N-1:0] alloc_map;

  // Overflow takes precedence: a full list has every bit clear.
  assign dbl_hit = free_acc && !list_full && !alloc_map[acc_page];

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      alloc_map         <= '0;
      double_free_err   <= 1'b0;
      double_free_count <= '0;
    end else begin
      if (pop)   alloc_map[out_data] <= 1'b1;
      if (wr_en) alloc_map[acc_page] <= 1'b0;
      double_free_err <= dbl_hit;
      if (dbl_hit && (double_free_count != '1))
        double_free_count <= double_free_count + DOUBLE_FREE_COUNT_WIDTH'(1);
    end
  end
`else
  assign dbl_hit           = 1'b0;
  assign double_free_err   = 1'b0;
  assign double_free_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_page_allocator.sv
// Directed bench for the page allocator at NUM_PAGES_LOG=4, NUM_FREE_PORTS=2.
module tb_p4_router_page_allocator;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        init_done;
  logic [4:0]  num_free_pages;
  logic        overflow_err;
  logic        double_free_err;
  logic [15:0] double_free_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  AXIS_int #(.DATA_W(16)) alloc_if ();
  AXIS_int #(.DATA_W(16)) free_if [2] ();

  p4_router_page_allocator #(
    .NUM_PAGES_LOG  (4),
    .NUM_FREE_PORTS (2),
    .DATA_W         (16)
  ) dut (
    .clk               (clk),
    .sresetn           (sresetn),
    .alloc_out         (alloc_if),
    .free_in           (free_if),
    .init_done         (init_done),
    .num_free_pages    (num_free_pages),
    .overflow_err      (overflow_err),
    .double_free_err   (double_free_err),
    .double_free_count (double_free_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic wait_alloc(input string tag);
    int n;
    n = 0;
    while (alloc_if.tvalid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(alloc_if.tvalid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (alloc_if.tvalid !== 1'b0 && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(alloc_if.tvalid), 32'd0);
  endtask

  initial begin
    sresetn = 1'b0;
    alloc_if.tready = 1'b0;
    free_if[0].tvalid = 1'b1;
    free_if[0].tdata  = 16'd9;
    free_if[1].tvalid = 1'b0;
    free_if[1].tdata  = 16'd0;
    tick();
    tick();

    // reset state
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_count", 32'(num_free_pages), 32'd0);
    check("rst_tvalid", 32'(alloc_if.tvalid), 32'd0);
    check("rst_tready0", 32'(free_if[0].tready), 32'd0);
    check("rst_tready1", 32'(free_if[1].tready), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_dbl", 32'(double_free_err), 32'd0);
    check("rst_dfc", 32'(double_free_count), 32'd0);

    // exactly 16 INIT cycles, streams stalled meanwhile
    alloc_if.tready = 1'b1;
    sresetn = 1'b1;
    repeat (15) tick();
    check("init_busy", 32'(init_done), 32'd0);
    check("init_tready0", 32'(free_if[0].tready), 32'd0);
    check("init_tvalid", 32'(alloc_if.tvalid), 32'd0);
    free_if[0].tvalid = 1'b0;
    tick();
    check("run_init_done", 32'(init_done), 32'd1);
    check("run_count", 32'(num_free_pages), 32'd16);

    // full burst 0..15 on consecutive cycles
    wait_alloc("burst_first_valid");
    for (int k = 0; k < 16; k++) begin
      check("burst_tvalid", 32'(alloc_if.tvalid), 32'd1);
      check("burst_tdata", 32'(alloc_if.tdata), 32'(k));
      check("burst_count", 32'(num_free_pages), 32'(16 - k));
      tick();
    end
    check("burst_end_tvalid", 32'(alloc_if.tvalid), 32'd0);
    check("burst_end_count", 32'(num_free_pages), 32'd0);

    // empty list: page 7 freed on port 1 reappears by t+2
    alloc_if.tready = 1'b0;
    free_if[1].tvalid = 1'b1;
    free_if[1].tdata  = 16'd7;
    #1;
    check("late_tready1", 32'(free_if[1].tready), 32'd1);
    check("late_tready0", 32'(free_if[0].tready), 32'd0);
    tick();
    free_if[1].tvalid = 1'b0;
    check("late_count_t1", 32'(num_free_pages), 32'd1);
    tick();
    check("late_tvalid_t2", 32'(alloc_if.tvalid), 32'd1);
    check("late_tdata_t2", 32'(alloc_if.tdata), 32'd7);
    check("late_count_t2", 32'(num_free_pages), 32'd1);
    alloc_if.tready = 1'b1;
    tick();
    check("late_count_after", 32'(num_free_pages), 32'd0);
    check("late_tvalid_after", 32'(alloc_if.tvalid), 32'd0);

    // both ports busy: grants alternate, count settles while allocating every cycle
    free_if[0].tvalid = 1'b1;
    free_if[0].tdata  = 16'd0;
    free_if[1].tvalid = 1'b1;
    free_if[1].tdata  = 16'd1;
    #1;
    check("rr_c0_g0", 32'(free_if[0].tready), 32'd1);
    check("rr_c0_g1", 32'(free_if[1].tready), 32'd0);
    check("rr_c0_count", 32'(num_free_pages), 32'd0);
    tick();
    free_if[0].tdata = 16'd2;
    #1;
    check("rr_c1_g0", 32'(free_if[0].tready), 32'd0);
    check("rr_c1_g1", 32'(free_if[1].tready), 32'd1);
    check("rr_c1_count", 32'(num_free_pages), 32'd1);
    tick();
    free_if[1].tdata = 16'd3;
    #1;
    check("rr_c2_g0", 32'(free_if[0].tready), 32'd1);
    check("rr_c2_g1", 32'(free_if[1].tready), 32'd0);
    check("rr_c2_count", 32'(num_free_pages), 32'd2);
    check("rr_c2_tdata", 32'(alloc_if.tdata), 32'd0);
    tick();
    free_if[0].tdata = 16'd4;
    #1;
    check("rr_c3_g0", 32'(free_if[0].tready), 32'd0);
    check("rr_c3_g1", 32'(free_if[1].tready), 32'd1);
    check("rr_c3_count", 32'(num_free_pages), 32'd2);
    check("rr_c3_tdata", 32'(alloc_if.tdata), 32'd1);
    tick();
    free_if[1].tvalid = 1'b0;
    #1;
    check("rr_c4_g0", 32'(free_if[0].tready), 32'd1);
    check("rr_c4_count", 32'(num_free_pages), 32'd2);
    check("rr_c4_tdata", 32'(alloc_if.tdata), 32'd2);
    tick();
    free_if[0].tvalid = 1'b0;
    check("rr_c5_count", 32'(num_free_pages), 32'd2);
    wait_drain("rr_drain");
    check("rr_drain_count", 32'(num_free_pages), 32'd0);

    // reset mid-burst with 5 pages outstanding
    sresetn = 1'b0;
    tick();
    tick();
    sresetn = 1'b1;
    wait_init("mid_init");
    check("mid_init_count", 32'(num_free_pages), 32'd16);
    wait_alloc("mid_first_valid");
    repeat (5) tick();
    check("mid_count", 32'(num_free_pages), 32'd11);
    check("mid_tdata", 32'(alloc_if.tdata), 32'd5);
    sresetn = 1'b0;
    tick();
    check("rstmid_count", 32'(num_free_pages), 32'd0);
    check("rstmid_tvalid", 32'(alloc_if.tvalid), 32'd0);
    check("rstmid_init_done", 32'(init_done), 32'd0);
    alloc_if.tready = 1'b0;
    sresetn = 1'b1;
    wait_init("reinit");
    check("reinit_count", 32'(num_free_pages), 32'd16);
    repeat (4) tick();
    check("reinit_tvalid", 32'(alloc_if.tvalid), 32'd1);
    check("reinit_tdata", 32'(alloc_if.tdata), 32'd0);
    check("reinit_count_held", 32'(num_free_pages), 32'd16);

    // free into a full list is dropped with a single overflow pulse
    free_if[0].tvalid = 1'b1;
    free_if[0].tdata  = 16'd3;
    #1;
    check("ovf_tready0", 32'(free_if[0].tready), 32'd1);
    tick();
    free_if[0].tvalid = 1'b0;
    check("ovf_pulse", 32'(overflow_err), 32'd1);
    check("ovf_no_dbl", 32'(double_free_err), 32'd0);
    check("ovf_count", 32'(num_free_pages), 32'd16);
    tick();
    check("ovf_pulse_end", 32'(overflow_err), 32'd0);
    check("ovf_count_end", 32'(num_free_pages), 32'd16);

    // allocate pages 0 and 1
    alloc_if.tready = 1'b1;
    tick();
    tick();
    alloc_if.tready = 1'b0;
    check("pre_df_count", 32'(num_free_pages), 32'd14);
    check("pre_df_tdata", 32'(alloc_if.tdata), 32'd2);

`ifdef P4_ROUTER_PAGE_ALLOC_DOUBLE_FREE_CHECK_EN
    free_if[0].tvalid = 1'b1;
    free_if[0].tdata  = 16'd0;
    #1;
    check("df_tready_first", 32'(free_if[0].tready), 32'd1);
    tick();
    check("df_first_err", 32'(double_free_err), 32'd0);
    check("df_first_count", 32'(num_free_pages), 32'd15);
    check("df_tready_second", 32'(free_if[0].tready), 32'd1);
    tick();
    free_if[0].tvalid = 1'b0;
    check("df_err", 32'(double_free_err), 32'd1);
    check("df_cnt", 32'(double_free_count), 32'd1);
    check("df_count", 32'(num_free_pages), 32'd15);
    check("df_no_ovf", 32'(overflow_err), 32'd0);
    tick();
    check("df_err_end", 32'(double_free_err), 32'd0);
    check("df_cnt_end", 32'(double_free_count), 32'd1);
`else
    check("nodf_err", 32'(double_free_err), 32'd0);
    check("nodf_cnt", 32'(double_free_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/p4_router_page_allocator.md
P4_ROUTER_PAGE_ALLOCATOR -- requirements
Module: p4_router_page_allocator

Interface
REQ-001 Parameter NUM_PAGES_LOG, default 10: log2 of page count N = 2^NUM_PAGES_LOG; SHALL be >= 2.
REQ-002 Parameter NUM_FREE_PORTS, default 2: number of independent free-return channels; SHALL be >= 1.
REQ-003 Port clk, input, 1: single clock for all logic and interfaces.
REQ-004 Port sresetn, input, 1: reset, synchronous and active-low.
REQ-005 Port alloc_out, AXIS_int.Master: page index in tdata[NUM_PAGES_LOG-1:0], upper tdata bits zero; tvalid/tready handshake.
REQ-006 Port free_in[NUM_FREE_PORTS], AXIS_int.Slave array: returned page index in tdata[NUM_PAGES_LOG-1:0].
REQ-007 Port init_done, output, 1: high once the free list is populated.
REQ-008 Port num_free_pages, output, NUM_PAGES_LOG+1: current free-page count, including any page held in the output register.
REQ-009 Port overflow_err, output, 1: one-cycle pulse when a free is dropped because the list is full.
REQ-010 Port double_free_err, output, 1: one-cycle pulse when a double free is dropped.
REQ-011 Port double_free_count, output, 16: saturating count of dropped double frees.

Function
REQ-012 Free list SHALL be a circular FIFO of N entries in RAM with 1-cycle read latency, plus one output register feeding alloc_out.
REQ-013 State machine SHALL have states INIT and RUN; reset enters INIT.
REQ-014 INIT SHALL write page indices 0..N-1 in ascending order, one per cycle, then enter RUN; alloc_out.tvalid=0 and all free_in tready=0 in INIT.
REQ-015 On entering RUN: init_done=1, num_free_pages=N; first allocated page SHALL be 0, followed by 1, 2, ... in FIFO order.
REQ-016 alloc_out.tvalid SHALL be high iff the output register holds a page; tdata SHALL be stable while tvalid && !tready.
REQ-017 Output register SHALL refill from the FIFO head so that back-to-back allocations run at one page per cycle while num_free_pages > 1.
REQ-018 A round-robin arbiter SHALL accept at most one free per cycle; tready SHALL be high only on the granted port; priority rotates to the port after the last granted one.
REQ-019 With an empty list, a page freed in cycle t SHALL appear on alloc_out.tvalid no later than cycle t+2.
REQ-020 Simultaneous alloc and free handshakes in one cycle SHALL leave num_free_pages unchanged; the freed page SHALL enter the FIFO tail.
REQ-021 A free accepted while num_free_pages == N SHALL be dropped, overflow_err pulsed, and count and pointers unchanged.
REQ-022 FIFO pointers SHALL wrap modulo N; num_free_pages SHALL never exceed N or go below 0.

Reset
REQ-023 Reset SHALL drive: state=INIT, pointers=0, num_free_pages=0, init_done=0, all tvalid/tready=0, error pulses=0, double_free_count=0, arbiter pointer=port 0.
REQ-024 Reset asserted mid-operation SHALL discard all outstanding allocations; after re-INIT, all N pages are free.

Configuration
REQ-025 Macro P4_ROUTER_PAGE_ALLOC_DOUBLE_FREE_CHECK_EN defined: an N-bit allocated bitmap SHALL be kept; a bit is set on alloc handshake and cleared on accepted free.
REQ-026 With the macro defined, a free of a page whose bit is clear SHALL be accepted (tready), dropped, pulse double_free_err, and increment double_free_count, saturating at 16'hFFFF.
REQ-027 Macro undefined: no bitmap; double_free_err=0 and double_free_count=0 constantly.

Structure
REQ-028 Package p4_router_queue_pkg SHALL hold the allocator state enum and the DOUBLE_FREE_COUNT_WIDTH=16 constant.
REQ-029 Round-robin arbitration SHALL be sub-module p4_router_rr_arbiter, parametrised by NUM_FREE_PORTS.

Verification (NUM_PAGES_LOG=4, NUM_FREE_PORTS=2)
REQ-030 Reset release -> 16 INIT cycles, then init_done=1, num_free_pages=16; tready held high -> pages 0..15 on consecutive cycles, then tvalid=0, count=0.
REQ-031 Empty list, free page 7 on port 1 at cycle t -> alloc_out tvalid with tdata=7 by t+2; count 0->1->0.
REQ-032 Both ports hold a valid free each cycle -> grants alternate 0,1,0,1; concurrent alloc every cycle keeps the count constant.
REQ-033 Full list (16), free page 3 -> overflow_err pulses once; count stays 16.
REQ-034 With the macro defined, allocate page 0, free 0 twice -> second free raises double_free_err and double_free_count=1; count rises by exactly 1.
REQ-035 Assert sresetn mid-burst with 5 pages outstanding -> after re-INIT, count=16 and allocation restarts at page 0.
